// File: rtl/bowling_score_engine.sv
// -----------------------------------------------------------------------------
// bowling_score_engine
//   Multi-player bowling scorer. Rolls arrive one at a time over a valid/ready
//   handshake; the engine keeps a running score per player, resolves strike and
//   spare bonuses as later rolls come in, tracks whose turn it is and flags the
//   end of the game.
//
// Ports
//   clk            rising-edge clock
//   reset          asynchronous active-low reset, clears all state
//   new_game       synchronous one-cycle pulse, same effect as reset; wins over
//                  a roll offered in the same cycle
//   roll_valid     roll_pins is presented
//   roll_pins      pins knocked down by the offered roll
//   roll_ready     engine can accept a roll (READY state only)
//   illegal        one-cycle pulse: offered roll exceeded the standing pins and
//                  was dropped
//   cur_player     player whose roll is expected next
//   cur_frame      frame index, 1-based
//   cur_roll       roll index within the frame (0, 1, 2)
//   pins_standing  pins up for the next roll
//   rd_player      score readout select
//   rd_score       registered score of rd_player, one-cycle latency
//   game_done      high once the last player has completed the last frame
// -----------------------------------------------------------------------------
module bowling_score_engine #(
  parameter int NUM_PLAYERS = 2,
  parameter int NUM_FRAMES  = 10,
  parameter int PIN_COUNT   = 10,
  parameter int SCORE_W     = 10,
  localparam int PW = (NUM_PLAYERS > 1) ? $clog2(NUM_PLAYERS) : 1,
  localparam int FW = $clog2(NUM_FRAMES + 1)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               new_game,
  input  logic               roll_valid,
  input  logic [3:0]         roll_pins,
  output logic               roll_ready,
  output logic               illegal,
  output logic [PW-1:0]      cur_player,
  output logic [FW-1:0]      cur_frame,
  output logic [1:0]         cur_roll,
  output logic [3:0]         pins_standing,
  input  logic [PW-1:0]      rd_player,
  output logic [SCORE_W-1:0] rd_score,
  output logic               game_done
);

  localparam logic [1:0] S_READY  = 2'd0;
  localparam logic [1:0] S_UPDATE = 2'd1;
  localparam logic [1:0] S_DONE   = 2'd2;

  localparam logic [3:0]    PIN_MAX     = 4'(PIN_COUNT);
  localparam logic [FW-1:0] LAST_FRAME  = FW'(NUM_FRAMES);
  localparam logic [PW-1:0] LAST_PLAYER = PW'(NUM_PLAYERS - 1);

  logic [1:0]         state_q, state_d;
  logic [SCORE_W-1:0] score_q [NUM_PLAYERS];
  logic [SCORE_W-1:0] score_d [NUM_PLAYERS];
  // Two bonus counters per player: each holds how many upcoming rolls still
  // score double because of an earlier strike (2) or spare (1).
  logic [1:0]         pa_q [NUM_PLAYERS];
  logic [1:0]         pa_d [NUM_PLAYERS];
  logic [1:0]         pb_q [NUM_PLAYERS];
  logic [1:0]         pb_d [NUM_PLAYERS];
  logic [PW-1:0]      cur_player_q, cur_player_d;
  logic [FW-1:0]      cur_frame_q, cur_frame_d;
  logic [1:0]         cur_roll_q, cur_roll_d;
  logic [3:0]         pins_standing_q, pins_standing_d;
  logic               mark_q, mark_d;       // last frame has earned its fill ball
  logic [3:0]         roll_q, roll_d;       // roll latched for the UPDATE cycle
  logic               illegal_q, illegal_d;
  logic [SCORE_W-1:0] rd_score_q, rd_score_d;

  // Per-roll scoring terms for the current player; only consumed in UPDATE.
  logic [1:0]         pa_cur, pb_cur, pa_dec, pb_dec, bonus, mult;
  logic [5:0]         gain;
  logic [SCORE_W:0]   sum;
  logic [SCORE_W-1:0] new_score;
  logic               is_last, clears, strike, spare, frame_end, game_end;

  always_comb begin
    pa_cur  = pa_q[cur_player_q];
    pb_cur  = pb_q[cur_player_q];
    mult    = 2'd1 + {1'b0, pa_cur != 2'd0} + {1'b0, pb_cur != 2'd0};
    gain    = {2'b00, roll_q} * {4'b0000, mult};
    sum     = {1'b0, score_q[cur_player_q]} + (SCORE_W + 1)'(gain);
    new_score = sum[SCORE_W] ? '1 : sum[SCORE_W-1:0];
    pa_dec  = (pa_cur != 2'd0) ? pa_cur - 2'd1 : 2'd0;
    pb_dec  = (pb_cur != 2'd0) ? pb_cur - 2'd1 : 2'd0;

    is_last = (cur_frame_q == LAST_FRAME);
    clears  = (roll_q == pins_standing_q);
    strike  = (cur_roll_q == 2'd0) && clears;
    spare   = (cur_roll_q == 2'd1) && clears;
    bonus   = is_last ? 2'd0 : (strike ? 2'd2 : (spare ? 2'd1 : 2'd0));

    // The last frame runs to a third ball only if a mark was made on one of
    // its first two balls.
    if (is_last) begin
      frame_end = ((cur_roll_q == 2'd1) && !mark_q && !clears) ||
                  (cur_roll_q == 2'd2);
    end else begin
      frame_end = strike || (cur_roll_q == 2'd1);
    end
    game_end = frame_end && is_last && (cur_player_q == LAST_PLAYER);
  end

  // NOTE: every *_d gets its default from *_q first so that no path through
  // the case statement leaves a variable unassigned and infers a latch.
  always_comb begin
    state_d         = state_q;
    score_d         = score_q;
    pa_d            = pa_q;
    pb_d            = pb_q;
    cur_player_d    = cur_player_q;
    cur_frame_d     = cur_frame_q;
    cur_roll_d      = cur_roll_q;
    pins_standing_d = pins_standing_q;
    mark_d          = mark_q;
    roll_d          = roll_q;
    illegal_d       = 1'b0;
    rd_score_d      = '0;
    if ({1'b0, rd_player} < (PW + 1)'(NUM_PLAYERS)) begin
      rd_score_d = score_q[rd_player];
    end

    case (state_q)
      S_READY: begin
        if (roll_valid) begin
          if (roll_pins > pins_standing_q) begin
            illegal_d = 1'b1;
          end else begin
            roll_d  = roll_pins;
            state_d = S_UPDATE;
          end
        end
      end

      S_UPDATE: begin
        score_d[cur_player_q] = new_score;
        pa_d[cur_player_q]    = pa_dec;
        pb_d[cur_player_q]    = pb_dec;
        // A new bonus goes into whichever counter is idle after this roll.
        if (bonus != 2'd0) begin
          if (pa_dec == 2'd0) pa_d[cur_player_q] = bonus;
          else                pb_d[cur_player_q] = bonus;
        end

        if (frame_end) begin
          cur_roll_d      = 2'd0;
          mark_d          = 1'b0;
          pins_standing_d = PIN_MAX;
          // Position freezes on the final frame so cur_frame never exceeds
          // NUM_FRAMES.
          if (!game_end) begin
            if (cur_player_q == LAST_PLAYER) begin
              cur_player_d = '0;
              cur_frame_d  = cur_frame_q + 1'b1;
            end else begin
              cur_player_d = cur_player_q + 1'b1;
            end
          end
        end else begin
          cur_roll_d      = cur_roll_q + 2'd1;
          mark_d          = mark_q | clears;
          // Inside the last frame a cleared rack is reset for the fill ball.
          pins_standing_d = (is_last && clears) ? PIN_MAX
                                                : pins_standing_q - roll_q;
        end
        state_d = game_end ? S_DONE : S_READY;
      end

      S_DONE: begin
        state_d = S_DONE;
      end

      default: state_d = S_READY;
    endcase

    if (new_game) begin
      state_d         = S_READY;
      for (int i = 0; i < NUM_PLAYERS; i++) begin
        score_d[i] = '0;
        pa_d[i]    = 2'd0;
        pb_d[i]    = 2'd0;
      end
      cur_player_d    = '0;
      cur_frame_d     = FW'(1);
      cur_roll_d      = 2'd0;
      pins_standing_d = PIN_MAX;
      mark_d          = 1'b0;
      roll_d          = 4'd0;
      illegal_d       = 1'b0;
      rd_score_d      = '0;
    end
  end

  // NOTE: sequential state is updated with non-blocking assignments only, so
  // every flop samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q         <= S_READY;
      // NOTE: the per-player arrays are small flop banks, not RAM, so they are
      // cleared directly by reset.
      for (int i = 0; i < NUM_PLAYERS; i++) begin
        score_q[i] <= '0;
        pa_q[i]    <= 2'd0;
        pb_q[i]    <= 2'd0;
      end
      cur_player_q    <= '0;
      cur_frame_q     <= FW'(1);
      cur_roll_q      <= 2'd0;
      pins_standing_q <= PIN_MAX;
      mark_q          <= 1'b0;
      roll_q          <= 4'd0;
      illegal_q       <= 1'b0;
      rd_score_q      <= '0;
    end else begin
      state_q         <= state_d;
      score_q         <= score_d;
      pa_q            <= pa_d;
      pb_q            <= pb_d;
      cur_player_q    <= cur_player_d;
      cur_frame_q     <= cur_frame_d;
      cur_roll_q      <= cur_roll_d;
      pins_standing_q <= pins_standing_d;
      mark_q          <= mark_d;
      roll_q          <= roll_d;
      illegal_q       <= illegal_d;
      rd_score_q      <= rd_score_d;
    end
  end

  assign roll_ready    = (state_q == S_READY);
  assign game_done     = (state_q == S_DONE);
  assign illegal       = illegal_q;
  assign cur_player    = cur_player_q;
  assign cur_frame     = cur_frame_q;
  assign cur_roll      = cur_roll_q;
  assign pins_standing = pins_standing_q;
  assign rd_score      = rd_score_q;

endmodule

// File: doc/bowling_score_engine.md
Name: bowling_score_engine

Overview:
- Parametrised multi-player bowling scorer, successor to the single-lane scoreboard controller.
- Accepts one roll at a time (pins knocked) over a valid/ready handshake and keeps a running per-player score with strike/spare bonus resolution.
- Tracks turn order (player, frame, roll), rejects illegal pin counts and flags game completion.
- Sits between the pin-sensor front end and the display/readout logic.

Parameters:
- NUM_PLAYERS, 2, number of players in rotation (1..8)
- NUM_FRAMES, 10, frames per game; the last frame allows fill balls (>=2)
- PIN_COUNT, 10, pins per rack (1..15)
- SCORE_W, 10, per-player score register width; must hold NUM_FRAMES*3*PIN_COUNT

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low; clears all state
- new_game  in  1  synchronous one-cycle pulse; clears scores and position, same effect as reset
- roll_valid  in  1  roll_pins is presented
- roll_pins  in  4  pins knocked down by this roll
- roll_ready  out  1  engine can accept a roll
- illegal  out  1  one-cycle pulse: offered roll exceeded standing pins and was dropped
- cur_player  out  $clog2(NUM_PLAYERS) max 1  player whose roll is expected next
- cur_frame  out  $clog2(NUM_FRAMES+1)  frame index, 1-based
- cur_roll  out  2  roll index within frame (0,1,2)
- pins_standing  out  4  pins up for the next roll
- rd_player  in  $clog2(NUM_PLAYERS) max 1  score readout select
- rd_score  out  SCORE_W  registered score of rd_player, one-cycle latency
- game_done  out  1  high once the last player completes the last frame

Behaviour:
- Reset / new_game values:
  - scores = 0, all bonus counters = 0
  - cur_player = 0, cur_frame = 1, cur_roll = 0
  - pins_standing = PIN_COUNT
  - illegal = 0, game_done = 0, rd_score = 0
  - state READY
- new_game takes priority over a simultaneous roll.
- FSM states: READY, UPDATE, DONE.
  - READY: roll_ready = 1. A roll is accepted when roll_valid && roll_ready.
    - roll_pins > pins_standing: pulse illegal the next cycle, stay in READY, change no other state.
    - Otherwise latch the roll and go to UPDATE.
  - UPDATE (exactly 1 cycle, roll_ready = 0): apply scoring and advance position.
    - Go to DONE if the game has finished, else back to READY.
    - Accept-to-next-ready latency is 2 cycles.
  - DONE: roll_ready = 0, game_done = 1. Stays here until reset or new_game.
- Scoring per player:
  - Each player has two bonus counters, pa and pb, each 0..2.
  - Per roll:
    - score += pins * (1 + (pa != 0) + (pb != 0))
    - decrement each nonzero counter
  - Bonus creation, only when cur_frame < NUM_FRAMES:
    - strike (first roll == PIN_COUNT): load 2 into the free counter
    - spare (second roll clears the rack): load 1 into the free counter
    - At most two counters are ever live; a third is impossible by construction.
  - Last frame: marks earn no new bonuses; fill balls score base pins only.
  - Score saturates at all-ones (cannot occur with legal parameters).
- Frame end and rack:
  - Frames before the last end after a strike or after 2 rolls.
  - Last frame:
    - ends after 2 rolls if no mark; otherwise after 3
    - rack resets to PIN_COUNT after a strike or spare inside the frame
  - pins_standing = pins_standing - roll_pins, otherwise PIN_COUNT at each new frame or rack reset.
- Turn advance at frame end: cur_player increments and wraps to 0. On wrap, cur_frame increments.
- Game end: last frame of player NUM_PLAYERS-1 ends, then game_done is set in the cycle after UPDATE.
- rd_score is registered from scores[rd_player] every cycle, including during DONE.
- Asynchronous reset mid-UPDATE discards the latched roll.

Test Plan:
- NUM_PLAYERS=1, 12 rolls of 10 -> rd_score=300; game_done rises after roll 12; illegal never pulses.
- NUM_PLAYERS=1, 21 rolls of 5 -> rd_score=150; cur_roll reaches 2 in frame 10.
- NUM_PLAYERS=1, frames of 9,0 ×10 -> rd_score=90 after 20 rolls; a 21st roll_valid is ignored (roll_ready=0).
- Frame 1 roll 7, then 5 offered -> illegal pulses 1 cycle, score stays 7, pins_standing=3. Roll 3 then gives a spare; next roll 4 -> score 7+3+4*2=18.
- NUM_PLAYERS=2: P0 strike, P1 3,4, P0 2,3 -> cur_player alternates 0,1,0; P0 score 20, P1 score 7; cur_frame=3 after P1's frame-2 turn.
- Reset asserted mid-game (frame 5) and between roll accept and UPDATE -> all outputs return to reset values immediately; new_game pulse gives the same result synchronously.
